// File: rtl/lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lut_arbiter
// Brief   : Round-robin arbiter feeding a reconfigurable 3-input LUT;
//           one result per three cycles.
// Revision: 1.0 - initial release
// ============================================================================
module lut_arbiter #(
    parameter int          NREQ        = 4,
    parameter logic [7:0]  RESET_TABLE = 8'h96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_table,
    input  logic [3:0]  req,
    input  logic [31:0] signal_0,
    input  logic [31:0] signal_1,
    input  logic [31:0] signal_2,
    input  logic [31:0] signal_3,
    output logic [3:0]  grant,
    output logic        result_valid,
    output logic [31:0] signal_A,
    output logic [1:0]  result_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [NREQ-1:0] c_ONE_HOT_0 = NREQ'(1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_ptr;
    logic [7:0]  r_table;
    logic [1:0]  r_win;
    logic [2:0]  r_op;
    logic [31:0] r_data;
    logic [1:0]  r_id;

    logic [1:0]  w_win;
    logic [1:0]  w_idx;
    logic        w_found;
    logic [2:0]  w_op_sel;
    logic [2:0]  w_lut_idx;
    logic        w_unused;

    // Only the low three operand bits feed the LUT.
    assign w_unused = ^{signal_0[31:3], signal_1[31:3], signal_2[31:3], signal_3[31:3]};

    always_comb begin
        w_win   = r_ptr;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_op_sel = 3'b000;
        case (w_win)
            2'd0:    w_op_sel = signal_0[2:0];
            2'd1:    w_op_sel = signal_1[2:0];
            2'd2:    w_op_sel = signal_2[2:0];
            default: w_op_sel = signal_3[2:0];
        endcase
    end

    // Operand bit 0 is the LUT index MSB.
    assign w_lut_idx = {r_op[0], r_op[1], r_op[2]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (|req) w_next = ST_EVAL;
            ST_EVAL: w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_table <= RESET_TABLE;
            r_win   <= 2'd0;
            r_op    <= 3'd0;
            r_data  <= 32'd0;
            r_id    <= 2'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we) r_table <= cfg_table;
                    if (|req) begin
                        r_win <= w_win;
                        r_op  <= w_op_sel;
                        r_ptr <= w_win + 2'd1;
                    end
                end
                ST_EVAL: begin
                    r_data <= {31'd0, r_table[w_lut_idx]};
                    r_id   <= r_win;
                end
                default: ;
            endcase
        end
    end

    assign result_valid = (r_state == ST_RESP);
    assign grant        = (r_state == ST_RESP) ? (c_ONE_HOT_0 << r_win) : '0;
    assign signal_A     = r_data;
    assign result_id    = r_id;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lut_arbiter
// Brief   : Directed + randomized self-checking bench for lut_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [7:0]  cfg_table;
    logic [3:0]  req;
    logic [31:0] s0, s1, s2, s3;
    logic [3:0]  grant;
    logic        result_valid;
    logic [31:0] signal_A;
    logic [1:0]  result_id;
    logic        busy;

    lut_arbiter #(.NREQ(4), .RESET_TABLE(8'h96)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_table(cfg_table), .req(req),
        .signal_0(s0), .signal_1(s1), .signal_2(s2), .signal_3(s3),
        .grant(grant), .result_valid(result_valid), .signal_A(signal_A),
        .result_id(result_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: transaction-level view of the arbiter.
    int          m_ptr;
    logic [7:0]  m_table;
    logic [31:0] m_A;
    logic [1:0]  m_id;
    int          resp_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".valid"}, 32'(result_valid), 32'd0);
        chk({tag, ".grant"}, 32'(grant), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".A"}, signal_A, m_A);
        chk({tag, ".id"}, 32'(result_id), 32'(m_id));
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_table = 8'h96;
        m_A     = 32'd0;
        m_id    = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'd0; cfg_we = 1'b0; cfg_table = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One full request/eval/response transaction, starting with the DUT in IDLE.
    task automatic txn(input string tag, input logic [3:0] r,
                       input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3,
                       input bit we, input logic [7:0] tbl,
                       input bit keep, input bit scramble, input bit we_eval);
        int          w;
        int          idx;
        logic [31:0] op;
        req = r; s0 = v0; s1 = v1; s2 = v2; s3 = v3;
        cfg_we = we; cfg_table = tbl;
        if (we) m_table = tbl;
        w = -1;
        for (int i = 0; i < 4; i++)
            if (w < 0 && r[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
        op  = (w == 0) ? v0 : (w == 1) ? v1 : (w == 2) ? v2 : v3;
        idx = int'(op[0]) * 4 + int'(op[1]) * 2 + int'(op[2]);
        m_A   = {31'd0, m_table[idx]};
        m_id  = 2'(w);
        m_ptr = (w + 1) % 4;

        tick();
        cfg_we = 1'b0;
        chk({tag, ".eval_busy"}, 32'(busy), 32'd1);
        chk({tag, ".eval_valid"}, 32'(result_valid), 32'd0);
        if (!keep) req = 4'd0;
        if (scramble) begin
            s0 = $urandom; s1 = $urandom; s2 = $urandom; s3 = $urandom;
        end
        if (we_eval) begin
            cfg_we = 1'b1; cfg_table = 8'hFF;
        end

        tick();
        cfg_we = 1'b0;
        resp_cyc = cyc;
        chk({tag, ".valid"}, 32'(result_valid), 32'd1);
        chk({tag, ".grant"}, 32'(grant), 32'd1 << w);
        chk({tag, ".id"}, 32'(result_id), 32'(w));
        chk({tag, ".A"}, signal_A, m_A);
        chk({tag, ".busy"}, 32'(busy), 32'd1);

        tick();
        check_idle({tag, ".after"});
    endtask

    int          prev_cyc;
    logic [3:0]  rr;
    logic [31:0] rv [4];

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_table = 8'd0; req = 4'd0;
        s0 = 32'd0; s1 = 32'd0; s2 = 32'd0; s3 = 32'd0;

        do_reset();
        check_idle("reset");

        txn("basic", 4'b0001, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("basic.literal", signal_A, 32'h1);

        for (int k = 0; k < 8; k++)
            txn("parity", 4'b0100, $urandom, $urandom, 32'(k), $urandom,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Held all-request: fair rotation, one result every third cycle.
        do_reset();
        prev_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            txn("rr", 4'b1111, $urandom, $urandom, $urandom, $urandom,
                1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("rr.order", 32'(result_id), 32'(k));
            if (k > 0) chk("rr.gap", 32'(resp_cyc - prev_cyc), 32'd3);
            prev_cyc = resp_cyc;
        end

        txn("cfg", 4'b0100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        chk("cfg.literal", signal_A, 32'h1);
        txn("cfg_ign", 4'b0100, 32'h0, 32'h0, 32'h1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("cfg_ign.literal", signal_A, 32'h0);

        req = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_idle("noreq");
        end

        txn("capture", 4'b0010, $urandom, 32'h3, $urandom, $urandom,
            1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset during EVAL aborts the transaction and restores the table.
        req = 4'b0010; s1 = 32'h5;
        tick();
        rst = 1'b1; cfg_we = 1'b1; cfg_table = 8'h00; req = 4'd0;
        tick();
        rst = 1'b0; cfg_we = 1'b0;
        model_reset();
        check_idle("abort");
        tick();
        check_idle("abort2");
        txn("post_abort", 4'b1111, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_abort.literal", signal_A, 32'h1);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                req = 4'd0; cfg_we = 1'b1; cfg_table = 8'($urandom);
                m_table = cfg_table;
                tick();
                cfg_we = 1'b0;
                check_idle("rnd_cfg");
            end
            rr = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) rv[k] = $urandom;
            txn("rnd", rr, rv[0], rv[1], rv[2], rv[3],
                ($urandom_range(0, 3) == 0), 8'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
